// File: rtl/ac_mode_scheduler.sv
// Air-conditioner mode scheduler: registered mode, hysteresis demand, minimum
// run / lockout timing and vacancy energy save around a six-state FSM.
module ac_mode_scheduler #(
  parameter int TEMP_W         = 8,
  parameter int HYST           = 2,
  parameter int MIN_RUN        = 60,
  parameter int MIN_OFF        = 30,
  parameter int VACANT_TIMEOUT = 600
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              tick_i,
  input  logic [TEMP_W-1:0] temperature_i,
  input  logic [TEMP_W-1:0] setpoint_i,
  input  logic [1:0]        mode_req_i,
  input  logic              mode_req_valid_i,
  input  logic              window_open_i,
  input  logic              occupancy_i,
  output logic [1:0]        ac_working_mode_o,
  output logic              ac_heat_o,
  output logic              ac_cool_o,
  output logic              energy_save_o,
  output logic              lockout_o,
  output logic [2:0]        dbg_state_o
);

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_HEAT = 3'd2;
  localparam logic [2:0] S_COOL = 3'd3;
  localparam logic [2:0] S_LOCK = 3'd4;
  localparam logic [2:0] S_SAVE = 3'd5;

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_AUTO = 2'b01;
  localparam logic [1:0] M_HEAT = 2'b10;
  localparam logic [1:0] M_COOL = 2'b11;

  localparam int DW    = TEMP_W + 2;
  localparam int RUN_W = (MIN_RUN > 0) ? $clog2(MIN_RUN + 1) : 1;
  localparam int OFF_W = (MIN_OFF > 0) ? $clog2(MIN_OFF + 1) : 1;
  localparam int VAC_W = (VACANT_TIMEOUT > 0) ? $clog2(VACANT_TIMEOUT + 1) : 1;

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_RUN);
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(MIN_OFF);
  localparam logic [VAC_W-1:0] VAC_MAX = VAC_W'(VACANT_TIMEOUT);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [1:0]       r_mode;
  logic [RUN_W-1:0] r_run_cnt;
  logic [OFF_W-1:0] r_off_cnt;
  logic [VAC_W-1:0] r_vac_cnt;
  logic             r_heat;
  logic             r_cool;
  logic             r_save;
  logic             r_lock;

  logic signed [DW-1:0] w_temp_s;
  logic signed [DW-1:0] w_sp_s;
  logic signed [DW-1:0] w_hyst_s;
  logic                 w_heat_dem;
  logic                 w_cool_dem;
  logic                 w_heat_sat;
  logic                 w_cool_sat;
  logic                 w_heat_ok;
  logic                 w_cool_ok;
  logic                 w_save_cond;

  // Two extra bits keep setpoint-HYST and setpoint+HYST from wrapping at 0 or full scale.
  assign w_temp_s   = $signed({2'b00, temperature_i});
  assign w_sp_s     = $signed({2'b00, setpoint_i});
  assign w_hyst_s   = DW'(HYST);
  assign w_heat_dem = w_temp_s < (w_sp_s - w_hyst_s);
  assign w_cool_dem = w_temp_s > (w_sp_s + w_hyst_s);
  assign w_heat_sat = temperature_i >= setpoint_i;
  assign w_cool_sat = temperature_i <= setpoint_i;

  assign w_heat_ok   = (r_mode == M_AUTO) || (r_mode == M_HEAT);
  assign w_cool_ok   = (r_mode == M_AUTO) || (r_mode == M_COOL);
  assign w_save_cond = window_open_i || (r_vac_cnt >= VAC_MAX);

  // Earlier branches win: forced stop, then mode, then demand, then save.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OFF: begin
        if (r_mode != M_OFF) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (r_mode == M_OFF)                 w_next = S_OFF;
        else if (window_open_i)              w_next = S_SAVE;
        else if (w_heat_dem && w_heat_ok)    w_next = S_HEAT;
        else if (w_cool_dem && w_cool_ok)    w_next = S_COOL;
        else if (w_save_cond)                w_next = S_SAVE;
      end
      S_HEAT: begin
        if (window_open_i || !w_heat_ok)              w_next = S_LOCK;
        else if (w_heat_sat && (r_run_cnt >= RUN_MAX)) w_next = S_LOCK;
      end
      S_COOL: begin
        if (window_open_i || !w_cool_ok)              w_next = S_LOCK;
        else if (w_cool_sat && (r_run_cnt >= RUN_MAX)) w_next = S_LOCK;
      end
      S_LOCK: begin
        if (r_off_cnt >= OFF_MAX) begin
          if (r_mode == M_OFF)   w_next = S_OFF;
          else if (w_save_cond)  w_next = S_SAVE;
          else                   w_next = S_IDLE;
        end
      end
      S_SAVE: begin
        if (r_mode == M_OFF)     w_next = S_OFF;
        else if (!w_save_cond)   w_next = S_IDLE;
      end
      default: w_next = S_OFF;
    endcase
  end

  // mode_req_valid_i is a one-cycle qualifier with no ready: a request is taken
  // on the edge where valid is high, and the FSM acts on it one cycle later.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= S_OFF;
      r_mode    <= M_OFF;
      r_run_cnt <= '0;
      r_off_cnt <= '0;
      r_vac_cnt <= '0;
      r_heat    <= 1'b0;
      r_cool    <= 1'b0;
      r_save    <= 1'b0;
      r_lock    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (mode_req_valid_i && (mode_req_i != r_mode)) r_mode <= mode_req_i;

      if (w_next != r_state)                      r_run_cnt <= '0;
      else if (tick_i && (r_run_cnt != RUN_MAX))  r_run_cnt <= r_run_cnt + 1'b1;

      if (w_next != r_state)                      r_off_cnt <= '0;
      else if (tick_i && (r_off_cnt != OFF_MAX))  r_off_cnt <= r_off_cnt + 1'b1;

      if (occupancy_i)                            r_vac_cnt <= '0;
      else if (tick_i && (r_vac_cnt != VAC_MAX))  r_vac_cnt <= r_vac_cnt + 1'b1;

      r_heat <= (w_next == S_HEAT);
      r_cool <= (w_next == S_COOL);
      r_save <= (w_next == S_SAVE);
      r_lock <= (w_next == S_LOCK);
    end
  end

  assign ac_working_mode_o = r_mode;
  assign ac_heat_o         = r_heat;
  assign ac_cool_o         = r_cool;
  assign energy_save_o     = r_save;
  assign lockout_o         = r_lock;
  assign dbg_state_o       = r_state;

endmodule

// File: tb/tb_ac_mode_scheduler.sv
// Directed bench for ac_mode_scheduler: heat cycle, deadband, forced stop,
// boundaries, vacancy and reset mid-run, all with hand-computed expectations.
module tb_ac_mode_scheduler;

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_HEAT = 3'd2;
  localparam logic [2:0] S_COOL = 3'd3;
  localparam logic [2:0] S_LOCK = 3'd4;
  localparam logic [2:0] S_SAVE = 3'd5;

  logic       clk_i;
  logic       rst_n_i;
  logic       tick_i;
  logic [7:0] temperature_i;
  logic [7:0] setpoint_i;
  logic [1:0] mode_req_i;
  logic       mode_req_valid_i;
  logic       window_open_i;
  logic       occupancy_i;
  logic [1:0] ac_working_mode_o;
  logic       ac_heat_o;
  logic       ac_cool_o;
  logic       energy_save_o;
  logic       lockout_o;
  logic [2:0] dbg_state_o;

  int n_checks;
  int n_errors;

  ac_mode_scheduler #(
    .TEMP_W(8), .HYST(2), .MIN_RUN(4), .MIN_OFF(3), .VACANT_TIMEOUT(5)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .tick_i(tick_i),
    .temperature_i(temperature_i), .setpoint_i(setpoint_i),
    .mode_req_i(mode_req_i), .mode_req_valid_i(mode_req_valid_i),
    .window_open_i(window_open_i), .occupancy_i(occupancy_i),
    .ac_working_mode_o(ac_working_mode_o), .ac_heat_o(ac_heat_o),
    .ac_cool_o(ac_cool_o), .energy_save_o(energy_save_o),
    .lockout_o(lockout_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled just after the falling edge
  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic tick();
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(input logic [1:0] m);
    mode_req_i       = m;
    mode_req_valid_i = 1'b1;
    cyc();
    mode_req_valid_i = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic h,
                            input logic c, input logic s, input logic l);
    check({tag, "_state"}, 32'(dbg_state_o), 32'(st));
    check({tag, "_heat"},  32'(ac_heat_o),   32'(h));
    check({tag, "_cool"},  32'(ac_cool_o),   32'(c));
    check({tag, "_save"},  32'(energy_save_o), 32'(s));
    check({tag, "_lock"},  32'(lockout_o),   32'(l));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n_i = 1'b0; tick_i = 1'b0; temperature_i = 8'd22; setpoint_i = 8'd22;
    mode_req_i = 2'b00; mode_req_valid_i = 1'b0; window_open_i = 1'b0; occupancy_i = 1'b1;

    // reset state and no spontaneous exit from OFF
    repeat (2) cyc();
    check_outs("rst", S_OFF, 0, 0, 0, 0);
    check("rst_mode", 32'(ac_working_mode_o), 32'd0);
    rst_n_i = 1'b1;
    repeat (3) cyc();
    check("post_rst_off", 32'(dbg_state_o), 32'(S_OFF));

    // heat cycle: mode loads on the request edge, IDLE next, HEATING after
    temperature_i = 8'd19;
    req(2'b01);
    check("heat_mode_loaded", 32'(ac_working_mode_o), 32'd1);
    check("heat_still_off", 32'(dbg_state_o), 32'(S_OFF));
    cyc();
    check_outs("heat_idle", S_IDLE, 0, 0, 0, 0);
    cyc();
    check_outs("heat_on", S_HEAT, 1, 0, 0, 0);
    ticks(2);
    temperature_i = 8'd22;
    tick();
    check("heat_min_run_t3", 32'(ac_heat_o), 32'd1);
    tick();
    check("heat_min_run_t4", 32'(ac_heat_o), 32'd1);
    cyc();
    check_outs("heat_lock", S_LOCK, 0, 0, 0, 1);
    ticks(3);
    check("heat_lock_held", 32'(lockout_o), 32'd1);
    cyc();
    check_outs("heat_lock_exit", S_IDLE, 0, 0, 0, 0);

    // deadband: 20..24 around setpoint 22 never starts an actuator
    for (int t = 20; t <= 24; t++) begin
      temperature_i = 8'(t);
      repeat (2) cyc();
      check($sformatf("deadband_%0d_heat", t), 32'(ac_heat_o), 32'd0);
      check($sformatf("deadband_%0d_cool", t), 32'(ac_cool_o), 32'd0);
    end
    temperature_i = 8'd25;
    cyc();
    check_outs("cool_on", S_COOL, 0, 1, 0, 0);

    // forced stop by window, lockout not shortened, then save, then idle
    tick();
    window_open_i = 1'b1;
    cyc();
    check_outs("forced_lock", S_LOCK, 0, 0, 0, 1);
    ticks(3);
    check("forced_lock_held", 32'(lockout_o), 32'd1);
    cyc();
    check_outs("forced_save", S_SAVE, 0, 0, 1, 0);
    window_open_i = 1'b0;
    temperature_i = 8'd22;
    cyc();
    check_outs("window_closed", S_IDLE, 0, 0, 0, 0);

    // boundaries: no wrap at 0 or full scale
    setpoint_i = 8'd0; temperature_i = 8'd0;
    repeat (2) cyc();
    check_outs("bound_zero", S_IDLE, 0, 0, 0, 0);
    setpoint_i = 8'd255; temperature_i = 8'd255;
    repeat (2) cyc();
    check_outs("bound_max", S_IDLE, 0, 0, 0, 0);
    req(2'b10);
    check("heat_only_mode", 32'(ac_working_mode_o), 32'd2);
    setpoint_i = 8'd22; temperature_i = 8'd30;
    repeat (2) cyc();
    check_outs("heat_only_hot", S_IDLE, 0, 0, 0, 0);

    // mode that excludes the running direction forces a lockout
    temperature_i = 8'd19;
    cyc();
    check("heat_only_heat", 32'(ac_heat_o), 32'd1);
    req(2'b11);
    check("mode_first_heat_kept", 32'(ac_heat_o), 32'd1);
    cyc();
    check_outs("mode_forced_lock", S_LOCK, 0, 0, 0, 1);
    temperature_i = 8'd22;
    ticks(3);
    cyc();
    check_outs("mode_lock_exit", S_IDLE, 0, 0, 0, 0);

    // vacancy: occupancy pulse after 4 ticks restarts the count
    occupancy_i = 1'b0;
    ticks(4);
    occupancy_i = 1'b1;
    cyc();
    occupancy_i = 1'b0;
    ticks(4);
    check("vac_restart", 32'(energy_save_o), 32'd0);
    tick();
    check("vac_t5_edge", 32'(energy_save_o), 32'd0);
    cyc();
    check_outs("vac_save", S_SAVE, 0, 0, 1, 0);
    occupancy_i = 1'b1;
    cyc();
    check("vac_save_hold", 32'(energy_save_o), 32'd1);
    cyc();
    check_outs("vac_back", S_IDLE, 0, 0, 0, 0);

    // reset during HEATING
    temperature_i = 8'd19;
    req(2'b01);
    cyc();
    check("pre_rst_heat", 32'(ac_heat_o), 32'd1);
    tick();
    rst_n_i = 1'b0;
    cyc();
    check_outs("midrun_rst", S_OFF, 0, 0, 0, 0);
    check("midrun_rst_mode", 32'(ac_working_mode_o), 32'd0);
    rst_n_i = 1'b1;
    repeat (3) cyc();
    req(2'b00);
    cyc();
    check_outs("rst_stay_off", S_OFF, 0, 0, 0, 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
